// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and direction/mode constants for counter_ctrl
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DN       = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_FREERUN = 1'b1;

endpackage

// File: rtl/count_core.sv
// rtl/count_core.sv - WIDTH-bit up/down count register with clear, load, enable and reload
module count_core
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_reload,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Reload restarts a free-run cycle from the far end of the direction of travel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_reload) begin
            r_count <= (i_dir == DIR_DN) ? '1 : '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= (i_dir == DIR_DN) ? r_count - 1'b1 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/stop/pause/load counter controller FSM driving count_core
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_wrap;
    logic             w_load;
    logic             w_en;
    logic             w_reload;
    logic [WIDTH-1:0] w_count;
    logic             w_at_limit;

    assign w_at_limit = (w_count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wrap  <= w_reload;
        end
    end

    // Priority stop > pause > start > load > step is expressed by the if-chain order.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_reload     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!stop) begin
                    if (start) begin
                        w_state_next = ST_RUN;
                    end
                    w_load = load;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (pause) begin
                    w_state_next = ST_PAUSE;
                end else if (w_at_limit) begin
                    if (mode == MODE_FREERUN) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (!pause && start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    count_core #(
        .WIDTH(WIDTH)
    ) u_count_core (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_load_val (load_val),
        .i_en       (w_en),
        .i_dir      (dir),
        .i_reload   (w_reload),
        .o_count    (w_count)
    );

    assign count = w_count;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done  = (r_state == ST_DONE);
    assign wrap  = r_wrap;

endmodule
